// File: rtl/awg_pkg.sv
// Shared types and constants for the AWG command datapath.
package awg_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ERR_W  = 2;

    // Frame defaults
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_RAM_DEF   = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_REG_DEF   = 8'h02;

    // err_code encodings
    localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [ERR_W-1:0] ERR_BAD_CMD  = 2'd1;
    localparam logic [ERR_W-1:0] ERR_BAD_LEN  = 2'd2;
    localparam logic [ERR_W-1:0] ERR_CHECKSUM = 2'd3;

    // Parser frame position
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

endpackage

// File: rtl/byte_timeout.sv
// Restartable inter-byte watchdog: reloads on every byte, flags expiry when
// the count runs out while enabled and no byte arrives in that same cycle.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Down-counter held at the load value while disabled, stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_LOAD;
        end else if (restart || !enable) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign expired_c = enable && !restart && (cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into RAM-burst / register-write commands with XOR
// checksum, inter-byte timeout and resync on the next sync byte.
module uart_cmd_parser
    import awg_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [7:0]  CMD_RAM        = CMD_RAM_DEF,
    parameter logic [7:0]  CMD_REG        = CMD_REG_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_data,
    input  logic       data_valid,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    state_t            state;
    logic              is_reg;
    logic [BYTE_W-1:0] base_addr;
    logic [BYTE_W-1:0] offset;
    logic [BYTE_W-1:0] byte_cnt;
    logic [BYTE_W-1:0] chk_acc;
    logic [BYTE_W-1:0] shadow_data;
    logic              timeout_c;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (data_valid),
        .enable    (state != ST_IDLE),
        .expired_c (timeout_c)
    );

    // Frame FSM with registered strobes and held address/data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            is_reg      <= 1'b0;
            base_addr   <= '0;
            offset      <= '0;
            byte_cnt    <= '0;
            chk_acc     <= '0;
            shadow_data <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_TIMEOUT;
        end else begin
            ram_we    <= 1'b0;
            reg_we    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (data_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (uart_data == SYNC_BYTE) begin
                            state <= ST_CMD;
                        end
                    end

                    ST_CMD: begin
                        if (uart_data == CMD_RAM || uart_data == CMD_REG) begin
                            is_reg  <= (uart_data == CMD_REG);
                            chk_acc <= uart_data;
                            state   <= ST_ADDR;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_BAD_CMD;
                            state     <= ST_IDLE;
                        end
                    end

                    ST_ADDR: begin
                        base_addr <= uart_data;
                        chk_acc   <= chk_acc ^ uart_data;
                        state     <= ST_LEN;
                    end

                    ST_LEN: begin
                        chk_acc <= chk_acc ^ uart_data;
                        offset  <= '0;
                        if (is_reg && uart_data != 8'd1) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_BAD_LEN;
                            state     <= ST_IDLE;
                        end else if (uart_data == 8'd0) begin
                            state <= ST_CHK;
                        end else begin
                            byte_cnt <= uart_data;
                            state    <= ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        chk_acc <= chk_acc ^ uart_data;
                        if (is_reg) begin
                            shadow_data <= uart_data;
                        end else begin
                            // Address wraps naturally at 8 bits
                            ram_we    <= 1'b1;
                            ram_addr  <= base_addr + offset;
                            ram_wdata <= uart_data;
                            offset    <= offset + 8'd1;
                        end
                        byte_cnt <= byte_cnt - 8'd1;
                        if (byte_cnt == 8'd1) begin
                            state <= ST_CHK;
                        end
                    end

                    ST_CHK: begin
                        if (uart_data == chk_acc) begin
                            frame_ok <= 1'b1;
                            if (is_reg) begin
                                reg_we    <= 1'b1;
                                reg_addr  <= base_addr;
                                reg_wdata <= shadow_data;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHECKSUM;
                        end
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (timeout_c) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames, errors, wrap, timeout, reset.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] uart_data;
    logic       data_valid;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_last = 0;

    // Observed events
    logic [15:0] ram_q[$];
    logic [15:0] reg_q[$];
    int          ok_n = 0;
    int          err_n = 0;
    int          ok_cyc = 0;
    int          err_cyc = 0;
    int          reg_cyc = 0;

    logic [7:0] tx_q[$];

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_data  (uart_data),
        .data_valid (data_valid),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs mid-cycle
    always @(negedge clk) begin
        if (ram_we) ram_q.push_back({ram_addr, ram_wdata});
        if (reg_we) begin
            reg_q.push_back({reg_addr, reg_wdata});
            reg_cyc = cyc;
        end
        if (frame_ok) begin
            ok_n++;
            ok_cyc = cyc;
        end
        if (frame_err) begin
            err_n++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the queued bytes back-to-back, one per cycle
    task automatic send();
        while (tx_q.size() > 0) begin
            @(negedge clk);
            uart_data  = tx_q.pop_front();
            data_valid = 1'b1;
            tx_last    = cyc;
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic clear();
        ram_q.delete();
        reg_q.delete();
        ok_n  = 0;
        err_n = 0;
    endtask

    task automatic frame_end(input string tag, input int e_ok, input int e_err,
                             input int e_ram, input int e_reg);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_ok"},  32'(ok_n),         32'(e_ok));
        check({tag, "_err"}, 32'(err_n),        32'(e_err));
        check({tag, "_ram"}, 32'(ram_q.size()), 32'(e_ram));
        check({tag, "_reg"}, 32'(reg_q.size()), 32'(e_reg));
    endtask

    task automatic pop_ram(input string tag, input logic [15:0] exp);
        logic [15:0] o;
        o = 'x;
        if (ram_q.size() > 0) o = ram_q.pop_front();
        check(tag, 32'(o), 32'(exp));
    endtask

    task automatic pop_reg(input string tag, input logic [15:0] exp);
        logic [15:0] o;
        o = 'x;
        if (reg_q.size() > 0) o = reg_q.pop_front();
        check(tag, 32'(o), 32'(exp));
    endtask

    function automatic logic [39:0] outs();
        return {ram_we, ram_addr, ram_wdata, reg_we, reg_addr, reg_wdata,
                frame_ok, frame_err, err_code, 5'd0};
    endfunction

    initial begin
        int n;
        int t0;
        rst_n      = 1'b0;
        uart_data  = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'(outs() >> 8), 32'd0);
        rst_n = 1'b1;
        clear();

        // RAM burst: chk = 01^10^03^11^22^33 = 12
        tx_q = '{8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
        send();
        t0 = tx_last;
        frame_end("burst", 1, 0, 3, 0);
        pop_ram("burst_w0", 16'h1011);
        pop_ram("burst_w1", 16'h1122);
        pop_ram("burst_w2", 16'h1233);
        check("burst_ok_latency", 32'(ok_cyc), 32'(t0 + 1));
        check("burst_addr_hold", {24'd0, ram_addr}, 32'h12);
        clear();

        // Register write: chk = 02^05^01^7F = 79
        tx_q = '{8'hA5, 8'h02, 8'h05, 8'h01, 8'h7F, 8'h79};
        send();
        t0 = tx_last;
        frame_end("regw", 1, 0, 0, 1);
        pop_reg("regw_val", 16'h057F);
        check("regw_coincide", 32'(reg_cyc), 32'(ok_cyc));
        check("regw_latency", 32'(reg_cyc), 32'(t0 + 1));
        clear();

        // Same register frame, bad checksum
        tx_q = '{8'hA5, 8'h02, 8'h05, 8'h01, 8'h7F, 8'h00};
        send();
        frame_end("badchk", 0, 1, 0, 0);
        check("badchk_code", 32'(err_code), 32'd3);
        check("badchk_reg_hold", {16'd0, reg_addr, reg_wdata}, 32'h057F);
        clear();

        // Address wrap: chk = 01^FF^02^AA^BB = ED
        tx_q = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hED};
        send();
        frame_end("wrap", 1, 0, 2, 0);
        pop_ram("wrap_w0", 16'hFFAA);
        pop_ram("wrap_w1", 16'h00BB);
        clear();

        // Bad opcode
        tx_q = '{8'hA5, 8'h09};
        send();
        frame_end("badcmd", 0, 1, 0, 0);
        check("badcmd_code", 32'(err_code), 32'd1);
        clear();

        // Bad length on register write
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h02};
        send();
        frame_end("badlen", 0, 1, 0, 0);
        check("badlen_code", 32'(err_code), 32'd2);
        clear();

        // Following valid frame: chk = 01^20^01^5A = 7A
        tx_q = '{8'hA5, 8'h01, 8'h20, 8'h01, 8'h5A, 8'h7A};
        send();
        frame_end("recover", 1, 0, 1, 0);
        pop_ram("recover_w0", 16'h205A);
        clear();

        // Zero-length RAM burst: chk = 01^30^00 = 31
        tx_q = '{8'hA5, 8'h01, 8'h30, 8'h00, 8'h31};
        send();
        frame_end("len0", 1, 0, 0, 0);
        clear();

        // Timeout after A5 01: err two cycles past the TMO-cycle silence
        tx_q = '{8'hA5, 8'h01};
        send();
        t0 = tx_last;
        n  = 0;
        while (err_n == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tmo_seen", 32'(err_n), 32'd1);
        check("tmo_code", 32'(err_code), 32'd0);
        check("tmo_latency", 32'(err_cyc - t0), 32'(TMO + 2));
        frame_end("tmo", 0, 1, 0, 0);
        clear();

        // Noise then valid register frame: chk = 02^07^01^3C = 38
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h07, 8'h01, 8'h3C, 8'h38};
        send();
        frame_end("noise", 1, 0, 0, 1);
        pop_reg("noise_reg", 16'h073C);
        clear();

        // Byte lands on the exact expiry cycle: byte wins
        tx_q = '{8'hA5, 8'h01};
        send();
        t0 = tx_last;
        while (cyc < t0 + int'(TMO)) @(negedge clk);
        tx_q = '{8'h50, 8'h01, 8'h77, 8'h27};
        send();
        frame_end("race", 1, 0, 1, 0);
        pop_ram("race_w0", 16'h5077);
        clear();

        // Reset mid-DATA after 2 of 4 bytes
        tx_q = '{8'hA5, 8'h01, 8'h30, 8'h04, 8'h11, 8'h22};
        send();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 32'(outs() >> 8), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold", 32'(outs() >> 8), 32'd0);
        rst_n = 1'b1;
        frame_end("rst", 0, 0, 2, 0);
        pop_ram("rst_w0", 16'h3011);
        pop_ram("rst_w1", 16'h3122);
        clear();

        // Frame after reset: chk = 01^40^01^66 = 26
        tx_q = '{8'hA5, 8'h01, 8'h40, 8'h01, 8'h66, 8'h26};
        send();
        frame_end("post_rst", 1, 0, 1, 0);
        pop_ram("post_rst_w0", 16'h4066);
        clear();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
